// File: rtl/event_readout_if.sv
// Output word stream of event_readout: one W_OUT-bit word with a valid/ready handshake.
`timescale 1ns/1ps

// A word transfers on every clock edge where data_valid && data_ready. Once data_valid
// is raised, data_out and data_valid hold until that transfer happens.
interface event_readout_if #(
   parameter int W_OUT = 32
);
   logic [W_OUT-1:0] data_out;
   logic             data_valid;
   logic             data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/event_readout.sv
// Streams a snapshotted N_CH x N_SAMP event as header + payload (+ XOR trailer when
// EVENT_READOUT_TRAILER_EN is defined) words, then pulses event_saved for one cycle.
`timescale 1ns/1ps

module event_readout #(
   parameter int N_CH   = 16,
   parameter int N_SAMP = 64,
   parameter int W_OUT  = 32
) (
   input  logic                         clk_500,
   input  logic                         rst,
   input  logic                         evento_valid,
   input  logic [N_CH-1:0][N_SAMP-1:0]  evento,
   event_readout_if.master              out_if,
   output logic                         event_saved,
   output logic                         busy,
   output logic [15:0]                  event_count,
   output logic                         dropped,
   output logic [2:0]                   state_dbg
);
   localparam int WPC = N_SAMP / W_OUT;
   localparam int NW  = N_CH * WPC;
   localparam int KW  = (NW > 1) ? $clog2(NW) : 1;
   localparam int TOT = N_CH * N_SAMP;

`ifdef EVENT_READOUT_TRAILER_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_DONE    = 3'd3,
      S_TRAILER = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_DONE    = 3'd3
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [TOT-1:0]   snap_q, snap_d;
   logic [W_OUT-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [15:0]      count_q, count_d;
   logic             dropped_q, dropped_d;
`ifdef EVENT_READOUT_TRAILER_EN
   logic [W_OUT-1:0] acc_q, acc_d;
`endif

   logic             hs;
   logic [KW-1:0]    k_sel;
   logic [W_OUT-1:0] word_sel;

   assign hs = valid_q && out_if.data_ready;

   // Word k of the flattened snapshot is channel k/WPC, slice k%WPC.
   assign k_sel = (state_q == S_HEADER) ? '0 : k_q + KW'(1);

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < NW; i++) begin
         if (k_sel == KW'(i)) word_sel = snap_q[i*W_OUT +: W_OUT];
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      snap_d    = snap_q;
      data_d    = data_q;
      valid_d   = valid_q;
      count_d   = count_q;
      dropped_d = dropped_q;
`ifdef EVENT_READOUT_TRAILER_EN
      acc_d     = acc_q;
`endif

      if (evento_valid && state_q != S_IDLE) dropped_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (evento_valid) begin
               snap_d  = evento;
               data_d  = W_OUT'({16'hA5E7, count_q});
               valid_d = 1'b1;
               k_d     = '0;
`ifdef EVENT_READOUT_TRAILER_EN
               acc_d   = '0;
`endif
               state_d = S_HEADER;
            end
         end
         S_HEADER: begin
            if (hs) begin
               data_d  = word_sel;
               k_d     = '0;
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (hs) begin
`ifdef EVENT_READOUT_TRAILER_EN
               acc_d = acc_q ^ data_q;
`endif
               if (k_q == KW'(NW - 1)) begin
`ifdef EVENT_READOUT_TRAILER_EN
                  data_d  = acc_q ^ data_q;
                  state_d = S_TRAILER;
`else
                  data_d  = '0;
                  valid_d = 1'b0;
                  state_d = S_DONE;
`endif
               end else begin
                  k_d    = k_q + KW'(1);
                  data_d = word_sel;
               end
            end
         end
`ifdef EVENT_READOUT_TRAILER_EN
         S_TRAILER: begin
            if (hs) begin
               data_d  = '0;
               valid_d = 1'b0;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            count_d = count_q + 16'd1;
            k_d     = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_500) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         snap_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
         dropped_q <= 1'b0;
`ifdef EVENT_READOUT_TRAILER_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         snap_q    <= snap_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
         dropped_q <= dropped_d;
`ifdef EVENT_READOUT_TRAILER_EN
         acc_q     <= acc_d;
`endif
      end
   end

   assign out_if.data_out   = data_q;
   assign out_if.data_valid = valid_q;
   assign event_saved       = (state_q == S_DONE);
   assign busy              = (state_q != S_IDLE);
   assign event_count       = count_q;
   assign dropped           = dropped_q;
   assign state_dbg         = state_q;
endmodule

// File: doc/event_readout.md
# event_readout

Downstream stage of `sampler`. Takes a completed 16-channel × 64-sample event (`evento`) and streams it out as 32-bit words over a valid/ready handshake: one header word, the payload, and an optional trailer. When the last word has been accepted, it pulses `event_saved` back to `sampler` so the sampler can re-arm. Runs entirely in the 500 MHz sampling domain.

## Interface
Parameters:
- `N_CH`, 16, number of channels in `evento`
- `N_SAMP`, 64, samples (bits) per channel; must be a multiple of `W_OUT`
- `W_OUT`, 32, output word width

Ports:
- `clk_500`  in  1  sampling clock, 500 MHz
- `rst`  in  1  synchronous, active-high reset
- `evento_valid`  in  1  one-cycle pulse: `evento` holds a complete event
- `evento`  in  [N_CH-1:0][N_SAMP-1:0]  event bits from `sampler`
- `data_out`  out  W_OUT  output word
- `data_valid`  out  1  `data_out` is valid
- `data_ready`  in  1  consumer accepts the word when `data_valid && data_ready`
- `event_saved`  out  1  one-cycle pulse: event fully read out
- `busy`  out  1  high in any state except IDLE
- `event_count`  out  16  number of events completed
- `dropped`  out  1  sticky flag: an event arrived while busy

## Operation
- Word count per event: WPC = N_SAMP/W_OUT words per channel, NW = N_CH·WPC payload words. Defaults give WPC = 2 and NW = 32.
- FSM states: IDLE → HEADER → PAYLOAD → (TRAILER) → DONE → IDLE.
- IDLE:
  - On `evento_valid`: copy `evento` into an internal snapshot register, load the header, and go to HEADER.
  - The snapshot is independent of any later change on `evento`.
- HEADER:
  - `data_out = {16'hA5E7, event_count}`, using the count value before increment.
  - On handshake, go to PAYLOAD with word index k = 0.
- PAYLOAD:
  - Word k = snapshot[k/WPC][W_OUT·(k%WPC) +: W_OUT]. Order: channel 0 low word first, channel N_CH−1 high word last.
  - k increments on each handshake. After the handshake at k = NW−1, go to TRAILER if enabled, otherwise DONE.
- TRAILER: see Configuration. On handshake, go to DONE.
- DONE:
  - `event_saved = 1` for exactly this cycle.
  - `event_count` increments, wrapping 0xFFFF → 0x0000.
  - Next state is IDLE.
- Handshake rules:
  - `data_valid` is high only in HEADER, PAYLOAD and TRAILER.
  - While `data_valid && !data_ready`, `data_out` and `data_valid` hold stable.
  - `data_valid` never drops without a handshake.
- `evento_valid` in any state other than IDLE, including DONE: the event is ignored, `dropped` is set to 1, and the stream in progress is unaffected.
- `rst` at any cycle:
  - Next state is IDLE and k = 0.
  - `data_valid = 0`, `event_saved = 0`, `busy = 0`, `event_count = 0`, `dropped = 0`, `data_out = 0`.
  - A partial stream is abandoned and no `event_saved` is emitted.

## Timing
- `evento_valid` at edge t is registered. At edge t+1, `data_valid = 1` with the header and `busy = 1`.
- With `data_ready` held at 1:
  - One word per cycle.
  - Header at t+1, payload words at t+2 … t+NW+1.
  - Without trailer: `event_saved` at t+NW+2 (default t+34), back in IDLE at t+NW+3.
  - With trailer: every later step shifts by one cycle.
- The earliest cycle a new event can be accepted is the first IDLE cycle after DONE. Minimum event period is NW+3 cycles (35 with defaults), or 36 with the trailer.
- All outputs are registered; there are no combinational paths from `data_ready` or `evento_valid` to outputs.

## Configuration
- Macro: `EVENT_READOUT_TRAILER_EN`.
- Defined:
  - A TRAILER word follows the payload: `data_out` = XOR of all NW payload words.
  - The XOR accumulates in a register that clears on header load.
- Undefined:
  - No TRAILER state, no accumulator.
  - PAYLOAD goes straight to DONE, and the event length is 1+NW words.

## Test plan
- Reset: assert `rst` for 3 cycles → all outputs 0, FSM in IDLE; `event_count` = 0x0000.
- Single event, `data_ready` = 1, `evento[c]` = {32'hC000_0000|c<<16|1, 32'hC000_0000|c<<16|0}:
  - Header 0xA5E7_0000, then words 0xC000_0000, 0xC000_0001, 0xC001_0000 … 0xC00F_0001.
  - `event_saved` at t+34, `event_count` = 1.
  - With `EVENT_READOUT_TRAILER_EN`, the trailer is 0x0000_0000, computed per the XOR rule.
- Backpressure: drive `data_ready` low for 5 cycles on word k = 7 → `data_out` is held, no word is skipped or duplicated, and `event_saved` is delayed by exactly 5 cycles.
- Overlap: pulse `evento_valid` at k = 10 → stream unchanged, `dropped` = 1, and a second event after IDLE streams normally with header count 1.
- Snapshot: change `evento` to all-ones 1 cycle after `evento_valid` → the streamed payload matches the original values.
- Mid-stream reset: assert `rst` at k = 20 → `data_valid` = 0 next cycle, no `event_saved`, `event_count` = 0; a following event starts with header 0xA5E7_0000.
